decoder_nx2n_scan: RTL
======================

Name: decoder_nx2n_scan

Overview:
- Parametrised, registered N-to-2^N line decoder with enable. Successor to the team's 2x4 gate/dataflow decoder.
- Adds a clocked scan mode: an internal index counter steps through all outputs, with a programmable dwell time per output.
- Intended use: digit/row strobe generation for multiplexed display and keypad labs.
- Also usable as a plain registered decoder in direct mode.

Parameters:
- N, 2, select width. Output width is 2^N. Legal range 1..5.
- HOLD, 4, dwell in clock cycles per output in scan mode. Must be at least 1.
- HW, 3, width of the dwell counter. Must satisfy 2^HW >= HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  global enable. 0 forces all outputs inactive.
- mode  input  1  0 = direct decode of A; 1 = scan.
- A  input  N  select in direct mode; start index on scan entry.
- D  output  [0:2^N-1]  registered one-hot; D[k] is active when the selected/current index = k.
- idx  output  N  index currently decoded.
- wrap  output  1  one-cycle pulse in the cycle D returns to D[0] after D[2^N-1] in scan mode.

Behaviour:
- One clock; reset is asynchronous and active-low. Asserting rst_n low immediately clears the state regardless of clk.
- Reset values: state=IDLE, D all inactive (all 0), idx=0, wrap=0, dwell counter=0.
- State machine, evaluated each rising clk:
  - IDLE: enable=0. From IDLE, enable=1 & mode=0 -> DIRECT; enable=1 & mode=1 -> SCAN.
  - DIRECT: enable=0 -> IDLE; mode=1 -> SCAN.
  - SCAN: enable=0 -> IDLE; mode=0 -> DIRECT.
- Output in each state:
  - IDLE: D all inactive; idx and dwell hold their values; wrap=0.
  - DIRECT: idx<=A, D<=onehot(A), dwell=0. Latency is 1 cycle from A change to D.
  - SCAN, entry (from IDLE or DIRECT): idx<=A, D<=onehot(A), dwell<=0.
  - SCAN, steady: dwell increments each cycle. When dwell==HOLD-1: dwell<=0 and idx<=idx+1 modulo 2^N, so each output is active exactly HOLD cycles. HOLD=1 steps every cycle.
- Wrap: when idx steps from 2^N-1 to 0, wrap=1 for that cycle only, registered with D.
- Simultaneous events:
  - enable falling has priority over mode and A.
  - A changes during SCAN are ignored until the next scan entry.
- Exactly one D bit is active in DIRECT/SCAN; none is active in IDLE. No glitch cycles with zero or two active bits during steps.
- Reset mid-scan: outputs are inactive immediately. After release, the block restarts from IDLE and rescans from A.

Optional Feature:
- Macro DECODER_ACTIVE_LOW_OUT_EN.
- Defined: D is active-low. Reset/IDLE value is all 1s; the selected bit is 0. idx and wrap are unchanged.
- Undefined: active-high, as described above.

Test Plan:
- Reset, direct sweep: rst_n=0 then 1, enable=1, mode=0, N=2, A=0,1,2,3, each held 1 cycle -> D=1000,0100,0010,0001, each one cycle after A; idx tracks A.
- Disable: enable=0 with A=2 -> D=0000 on the next edge; idx holds 2. Re-enable -> D=0010.
- Scan: N=2, HOLD=4, A=1, mode 0->1 -> D=0100 for 4 cycles, then 0010 x4, then 0001 x4, then 1000 with wrap=1 for that single cycle; A changes mid-scan have no effect.
- HOLD=1 and N=3 -> D steps every cycle through all 8 bits; wrap pulses every 8 cycles.
- Async reset mid-scan: rst_n low between edges -> D=0, idx=0 with no clock edge. Release with enable=1, mode=1, A=3 -> scan restarts at 0001.
- DECODER_ACTIVE_LOW_OUT_EN defined, repeat the direct sweep -> D=0111,1011,1101,1110; reset/IDLE value is 1111.

Source files
------------

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N decoder with enable, direct mode and a timed scan mode.
// Define DECODER_ACTIVE_LOW_OUT_EN for active-low D outputs.
module decoder_nx2n_scan #(
    parameter int N    = 2,
    parameter int HOLD = 4,
    parameter int HW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [N-1:0]        A,
    output logic [0:(1<<N)-1]   D,
    output logic [N-1:0]        idx,
    output logic                wrap
);
    localparam int M = 1 << N;

`ifdef DECODER_ACTIVE_LOW_OUT_EN
    localparam logic ON = 1'b0;
`else
    localparam logic ON = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t         state, state_n;
    logic [N-1:0]   idx_n;
    logic [HW-1:0]  dwell, dwell_n;
    logic           wrap_n;
    logic [0:M-1]   d_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            D     <= {M{~ON}};
            idx   <= '0;
            wrap  <= 1'b0;
            dwell <= '0;
        end else begin
            state <= state_n;
            D     <= d_n;
            idx   <= idx_n;
            wrap  <= wrap_n;
            dwell <= dwell_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = mode ? SCAN : DIRECT;
            DIRECT:  if (!enable) state_n = IDLE; else if (mode)  state_n = SCAN;
            SCAN:    if (!enable) state_n = IDLE; else if (!mode) state_n = DIRECT;
            default: state_n = IDLE;
        endcase

        idx_n   = idx;
        dwell_n = dwell;
        wrap_n  = 1'b0;
        d_n     = {M{~ON}};
        // Actions key off the destination state so D/idx/wrap register together.
        case (state_n)
            DIRECT: begin
                idx_n   = A;
                dwell_n = '0;
            end
            SCAN: begin
                if (state != SCAN) begin
                    idx_n   = A;
                    dwell_n = '0;
                end else if (dwell == HW'(HOLD - 1)) begin
                    dwell_n = '0;
                    idx_n   = idx + 1'b1;
                    wrap_n  = (idx == {N{1'b1}});
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            default: ;
        endcase
        if (state_n != IDLE) d_n[idx_n] = ON;
    end

endmodule
